// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage_chain slice.
// CTRL_W and NUM_GPR are defined here because stage_t is built from them.
package pipe_pkg;

  localparam int CTRL_W  = 64;
  localparam int NUM_GPR = 8;
  localparam int RIDX_W  = $clog2(NUM_GPR);

  typedef logic [RIDX_W-1:0] ridx_t;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic              wr_en;
    logic              wb_mem;
    ridx_t             dst;
  } stage_t;

  // Operand constants; sign-extended to the datapath width when read.
  localparam int CONST_TABLE [8] = '{0, 1, 2, 4, 8, 16, 32, -1};

endpackage

// File: rtl/pipe_operand_read.sv
// One operand read port: constant/GPR select plus hazard detection.
// Defining PIPE_BYPASS_EN adds forwarding from in-flight results.
module pipe_operand_read
  import pipe_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int DATA_W    = 16,
  parameter int EX_STAGE  = 0,
  parameter int MEM_STAGE = 1
) (
  input  ridx_t                           sel,
  input  logic                            con,
  input  logic [NUM_GPR-1:0][DATA_W-1:0]  gpr,
  input  logic [DEPTH-1:0]                valid,
  input  logic [DEPTH-1:0]                wr_en,
  input  logic [DEPTH-1:0]                wb_mem,
  input  ridx_t [DEPTH-1:0]               dst,
  input  logic [DEPTH-1:0][DATA_W-1:0]    res,
  output logic [DATA_W-1:0]               data,
  output logic                            hazard
);

  // Results of stages at or before EX_STAGE are placeholders and never read.
  logic unused_ok;
  assign unused_ok = ^{res, wb_mem};

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    data   = gpr[sel];
    hazard = 1'b0;
    if (con) begin
      data = DATA_W'(CONST_TABLE[sel]);
    end else begin
`ifdef PIPE_BYPASS_EN
      // Walk oldest to youngest so the youngest match is the one that sticks.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid[k] && wr_en[k] && (dst[k] == sel)) begin
          if (k <= EX_STAGE || (wb_mem[k] && k <= MEM_STAGE)) begin
            hazard = 1'b1;
            data   = gpr[sel];
          end else begin
            hazard = 1'b0;
            data   = res[k];
          end
        end
      end
`else
      for (int k = 0; k < DEPTH; k++) begin
        if (valid[k] && wr_en[k] && (dst[k] == sel)) hazard = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Decoded-control shift chain with result alignment, GPR file, constants and masked PSW.
// Optional operand forwarding is enabled by defining PIPE_BYPASS_EN.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int                DEPTH        = 3,
  parameter int                DATA_W       = 16,
  parameter int                STALL_W      = 8,
  parameter int                EX_STAGE     = 0,
  parameter int                MEM_STAGE    = 1,
  parameter int                FLUSH_STAGES = 1,
  parameter logic [DATA_W-1:0] PSW_RESET    = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [STALL_W-1:0]               stall_in,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [CTRL_W-1:0]                in_ctrl,
  input  logic                             in_wr_en,
  input  logic                             in_wb_mem,
  input  logic [RIDX_W-1:0]                in_dst,
  input  logic [DATA_W-1:0]                exec_result,
  input  logic [DATA_W-1:0]                mem_result,
  input  logic [DATA_W-1:0]                psw_in,
  input  logic [DATA_W-1:0]                psw_mask,
  input  logic [RIDX_W-1:0]                rd_sel_a,
  input  logic [RIDX_W-1:0]                rd_sel_b,
  input  logic                             rd_con_a,
  input  logic                             rd_con_b,
  output logic [DEPTH-1:0]                 stage_valid_o,
  output logic [DEPTH-1:0][CTRL_W-1:0]     stage_ctrl_o,
  output logic [DEPTH-1:0][RIDX_W-1:0]     stage_dst_o,
  output logic [DATA_W-1:0]                rd_data_a,
  output logic [DATA_W-1:0]                rd_data_b,
  output logic                             hazard_o,
  output logic [DATA_W-1:0]                psw_o,
  output logic [DATA_W-1:0]                wb_result_o
);

  stage_t [DEPTH-1:0]             st;
  logic   [DEPTH-1:0][DATA_W-1:0] res;
  logic   [NUM_GPR-1:0][DATA_W-1:0] gpr;
  logic   [DATA_W-1:0]            psw;
  logic                           stall;

  logic   [DEPTH-1:0]             valid_vec;
  logic   [DEPTH-1:0]             wr_vec;
  logic   [DEPTH-1:0]             wbm_vec;
  ridx_t  [DEPTH-1:0]             dst_vec;
  logic                           hazard_a;
  logic                           hazard_b;

  assign stall = |stall_in;

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every stage samples pre-edge values.
    if (!rst_n) begin
      st  <= '0;
      res <= '0;
      // NOTE: the GPR file is a flop array, so clearing it in reset is cheap and makes reads defined.
      gpr <= '0;
      psw <= PSW_RESET;
    end else begin
      if (stall) begin
        st[0] <= '0;
      end else begin
        st[0] <= '{valid:  in_valid & ~flush,
                   ctrl:   in_ctrl,
                   wr_en:  in_wr_en,
                   wb_mem: in_wb_mem,
                   dst:    in_dst};
      end

      for (int k = 1; k < DEPTH; k++) begin
        st[k] <= st[k-1];
        if (flush && k < FLUSH_STAGES) st[k].valid <= 1'b0;
      end

      // Results ride alongside their instruction; loads replace the ALU value at MEM.
      res[0] <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        if (k == EX_STAGE + 1)
          res[k] <= exec_result;
        else if (k == MEM_STAGE + 1)
          res[k] <= st[MEM_STAGE].wb_mem ? mem_result : res[MEM_STAGE];
        else
          res[k] <= res[k-1];
      end

      if (st[DEPTH-1].valid && st[DEPTH-1].wr_en)
        gpr[st[DEPTH-1].dst] <= res[DEPTH-1];

      psw <= (psw & ~psw_mask) | (psw_in & psw_mask);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_valid_o[k] = st[k].valid;
      stage_ctrl_o[k]  = st[k].ctrl;
      stage_dst_o[k]   = st[k].dst;
      valid_vec[k]     = st[k].valid;
      wr_vec[k]        = st[k].wr_en;
      wbm_vec[k]       = st[k].wb_mem;
      dst_vec[k]       = st[k].dst;
    end
  end

  pipe_operand_read #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .EX_STAGE (EX_STAGE),
    .MEM_STAGE(MEM_STAGE)
  ) u_read_a (
    .sel   (rd_sel_a),
    .con   (rd_con_a),
    .gpr   (gpr),
    .valid (valid_vec),
    .wr_en (wr_vec),
    .wb_mem(wbm_vec),
    .dst   (dst_vec),
    .res   (res),
    .data  (rd_data_a),
    .hazard(hazard_a)
  );

  pipe_operand_read #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .EX_STAGE (EX_STAGE),
    .MEM_STAGE(MEM_STAGE)
  ) u_read_b (
    .sel   (rd_sel_b),
    .con   (rd_con_b),
    .gpr   (gpr),
    .valid (valid_vec),
    .wr_en (wr_vec),
    .wb_mem(wbm_vec),
    .dst   (dst_vec),
    .res   (res),
    .data  (rd_data_b),
    .hazard(hazard_b)
  );

  assign hazard_o    = hazard_a | hazard_b;
  assign psw_o       = psw;
  assign wb_result_o = res[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: PSW/constant vector table plus pipeline sequences.
// A second instance with FLUSH_STAGES=2 shares all inputs for the flush comparison.
module tb_pipe_stage_chain;

`ifdef PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  stall_in;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_ctrl;
  logic        in_wr_en;
  logic        in_wb_mem;
  logic [2:0]  in_dst;
  logic [15:0] exec_result;
  logic [15:0] mem_result;
  logic [15:0] psw_in;
  logic [15:0] psw_mask;
  logic [2:0]  rd_sel_a;
  logic [2:0]  rd_sel_b;
  logic        rd_con_a;
  logic        rd_con_b;

  logic [2:0]        valid;
  logic [2:0][63:0]  sctrl;
  logic [2:0][2:0]   sdst;
  logic [15:0]       rd_a;
  logic [15:0]       rd_b;
  logic              hazard;
  logic [15:0]       psw;
  logic [15:0]       wb_res;

  logic [2:0]        f2_valid;
  logic [2:0][63:0]  f2_ctrl;
  logic [2:0][2:0]   f2_dst;
  logic [15:0]       f2_rd_a;
  logic [15:0]       f2_rd_b;
  logic              f2_hazard;
  logic [15:0]       f2_psw;
  logic [15:0]       f2_wb_res;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.PSW_RESET(16'h00F0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wr_en(in_wr_en), .in_wb_mem(in_wb_mem),
    .in_dst(in_dst), .exec_result(exec_result), .mem_result(mem_result),
    .psw_in(psw_in), .psw_mask(psw_mask),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_con_a(rd_con_a), .rd_con_b(rd_con_b),
    .stage_valid_o(valid), .stage_ctrl_o(sctrl), .stage_dst_o(sdst),
    .rd_data_a(rd_a), .rd_data_b(rd_b), .hazard_o(hazard),
    .psw_o(psw), .wb_result_o(wb_res)
  );

  pipe_stage_chain #(.FLUSH_STAGES(2)) dut_f2 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wr_en(in_wr_en), .in_wb_mem(in_wb_mem),
    .in_dst(in_dst), .exec_result(exec_result), .mem_result(mem_result),
    .psw_in(psw_in), .psw_mask(psw_mask),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_con_a(rd_con_a), .rd_con_b(rd_con_b),
    .stage_valid_o(f2_valid), .stage_ctrl_o(f2_ctrl), .stage_dst_o(f2_dst),
    .rd_data_a(f2_rd_a), .rd_data_b(f2_rd_b), .hazard_o(f2_hazard),
    .psw_o(f2_psw), .wb_result_o(f2_wb_res)
  );

  typedef struct {
    logic [15:0] psw_in;
    logic [15:0] psw_mask;
    logic [15:0] exp_psw;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic we, input logic wm,
                        input logic [2:0] d, input logic [63:0] c);
    in_valid  = v;
    in_wr_en  = we;
    in_wb_mem = wm;
    in_dst    = d;
    in_ctrl   = c;
  endtask

  initial begin
    // psw_in, psw_mask, psw after edge, CONST[i], CONST[7-i]
    vecs[0] = '{16'hFFFF, 16'h0000, 16'h00F0, 16'h0000, 16'hFFFF};
    vecs[1] = '{16'hFFFF, 16'h000F, 16'h00FF, 16'h0001, 16'h0020};
    vecs[2] = '{16'h0000, 16'h00F0, 16'h000F, 16'h0002, 16'h0010};
    vecs[3] = '{16'h1234, 16'hFF00, 16'h120F, 16'h0004, 16'h0008};
    vecs[4] = '{16'hABCD, 16'hFFFF, 16'hABCD, 16'h0008, 16'h0004};
    vecs[5] = '{16'h0000, 16'h8001, 16'h2BCC, 16'h0010, 16'h0002};
    vecs[6] = '{16'hFFFF, 16'h0000, 16'h2BCC, 16'h0020, 16'h0001};
    vecs[7] = '{16'h0000, 16'h0000, 16'h2BCC, 16'hFFFF, 16'h0000};

    // Reset must win over a full stall, a flush and a valid input.
    rst_n = 1'b0; stall_in = 8'hFF; flush = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 3'd3, 64'hDEAD_BEEF_0000_0001);
    exec_result = 16'h1111; mem_result = 16'h2222;
    psw_in = 16'hFFFF; psw_mask = 16'hFFFF;
    rd_sel_a = 3'd3; rd_con_a = 1'b0; rd_sel_b = 3'd0; rd_con_b = 1'b0;
    tick(); tick();
    check("reset_valid", valid, 3'b000);
    check("reset_f2_valid", f2_valid, 3'b000);
    check("reset_psw", psw, 16'h00F0);
    check("reset_f2_psw", f2_psw, 16'h0000);
    check("reset_gpr3", rd_a, 16'h0000);
    check("reset_wb_result", wb_res, 16'h0000);
    check("reset_hazard", hazard, 1'b0);

    rst_n = 1'b1; stall_in = 8'h00; flush = 1'b0; psw_mask = 16'h0000;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    exec_result = 16'h0; mem_result = 16'h0;
    tick();

    // PSW masking and constant-table reads while the pipe is idle.
    for (int i = 0; i < 8; i++) begin
      psw_in = vecs[i].psw_in; psw_mask = vecs[i].psw_mask;
      rd_sel_a = 3'(i); rd_con_a = 1'b1;
      rd_sel_b = 3'(7 - i); rd_con_b = 1'b1;
      #1;
      check($sformatf("const_a[%0d]", i), rd_a, vecs[i].exp_a);
      check($sformatf("const_b[%0d]", i), rd_b, vecs[i].exp_b);
      check($sformatf("const_hazard[%0d]", i), hazard, 1'b0);
      tick();
      check($sformatf("psw[%0d]", i), psw, vecs[i].exp_psw);
    end
    psw_mask = 16'h0000;
    rd_con_a = 1'b0; rd_con_b = 1'b0; rd_sel_b = 3'd0;

    // ALU write to r2, with a dependent read of r2 behind it.
    set_in(1'b1, 1'b1, 1'b0, 3'd2, 64'hA1A1_0000_0000_00A1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    exec_result = 16'h1234; rd_sel_a = 3'd2; #1;
    check("alu_valid_s0", valid, 3'b001);
    check("alu_dst_s0", sdst[0], 3'd2);
    check("alu_ctrl_s0", sctrl[0], 64'hA1A1_0000_0000_00A1);
    check("alu_hazard_s0", hazard, 1'b1);
    tick();
    exec_result = 16'h0; #1;
    check("alu_valid_s1", valid, 3'b010);
    check("alu_hazard_s1", hazard, BYP ? 1'b0 : 1'b1);
    check("alu_rd_s1", rd_a, BYP ? 16'h1234 : 16'h0000);
    rd_con_a = 1'b1; #1;
    check("alu_const_no_hazard", hazard, 1'b0);
    check("alu_const_val", rd_a, 16'h0002);
    rd_con_a = 1'b0;
    tick();
    check("alu_wb_result", wb_res, 16'h1234);
    check("alu_valid_s2", valid, 3'b100);
    check("alu_hazard_s2", hazard, BYP ? 1'b0 : 1'b1);
    tick();
    check("alu_valid_done", valid, 3'b000);
    check("alu_gpr2", rd_a, 16'h1234);
    check("alu_hazard_done", hazard, 1'b0);

    // Load to r5: mem_result must replace the exec value riding with it.
    set_in(1'b1, 1'b1, 1'b1, 3'd5, 64'hB2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    exec_result = 16'h7777; rd_sel_a = 3'd5; #1;
    check("ld_hazard_s0", hazard, 1'b1);
    tick();
    exec_result = 16'h5555; mem_result = 16'hBEEF; #1;
    check("ld_hazard_s1", hazard, 1'b1);
    tick();
    exec_result = 16'h0; mem_result = 16'h0; #1;
    check("ld_wb_result", wb_res, 16'hBEEF);
    check("ld_rd_s2", rd_a, BYP ? 16'hBEEF : 16'h0000);
    check("ld_hazard_s2", hazard, BYP ? 1'b0 : 1'b1);
    tick();
    rd_sel_b = 3'd2; #1;
    check("ld_gpr5", rd_a, 16'hBEEF);
    check("ld_gpr2_kept", rd_b, 16'h1234);
    check("ld_hazard_done", hazard, 1'b0);
    rd_sel_b = 3'd0;

    // One-cycle stall with a continuous stream: the bubble walks down the pipe.
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 64'hC1); tick();
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 64'hC2); tick();
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 64'hC3); tick();
    check("stall_full", valid, 3'b111);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 64'hC4); stall_in = 8'h04;
    tick();
    check("stall_bubble_s0", valid, 3'b110);
    check("stall_bubble_ctrl", sctrl[0], 64'h0);
    check("stall_c3_s1", sctrl[1], 64'hC3);
    stall_in = 8'h00;
    tick();
    check("stall_bubble_s1", valid, 3'b101);
    check("stall_c4_entered", sctrl[0], 64'hC4);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 64'hC5);
    tick();
    check("stall_bubble_s2", valid, 3'b011);
    check("stall_c4_s1", sctrl[1], 64'hC4);
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    tick(); tick(); tick();
    check("stall_drained", valid, 3'b000);

    // Flush with three writers in flight; compare FLUSH_STAGES=1 and 2.
    set_in(1'b1, 1'b1, 1'b0, 3'd4, 64'hF1); tick();
    exec_result = 16'h4444;
    set_in(1'b1, 1'b1, 1'b0, 3'd7, 64'hF2); tick();
    exec_result = 16'h7777;
    set_in(1'b1, 1'b1, 1'b0, 3'd3, 64'hF3); tick();
    exec_result = 16'h3333;
    set_in(1'b1, 1'b1, 1'b0, 3'd1, 64'hF4); flush = 1'b1;
    tick();
    flush = 1'b0; exec_result = 16'h0;
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    check("flush1_valid", valid, 3'b110);
    check("flush2_valid", f2_valid, 3'b100);
    check("flush2_dst_s2", f2_dst[2], 3'd7);
    tick();
    rd_sel_a = 3'd4; rd_sel_b = 3'd7; #1;
    check("flush_gpr4", rd_a, 16'h4444);
    check("flush2_gpr4", f2_rd_a, 16'h4444);
    check("flush_gpr7", rd_b, 16'h7777);
    check("flush2_gpr7", f2_rd_b, 16'h7777);
    tick();
    rd_sel_a = 3'd3; rd_sel_b = 3'd1; #1;
    check("flush1_gpr3", rd_a, 16'h3333);
    check("flush2_gpr3", f2_rd_a, 16'h0000);
    check("flush_gpr1", rd_b, 16'h0000);
    check("flush_hazard", hazard, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
